// File: rtl/uart_tx_if.sv
// Write-side bus of the UART transmitter.
//   data_in    : byte to queue for transmission
//   data_wr    : write strobe, accepted on an edge where fifo_full is low
//   fifo_full  : transmit FIFO holds its full capacity
//   fifo_empty : transmit FIFO holds no words
//   overflow   : one-cycle pulse when a write was dropped because the FIFO was full
// The master modport is the producer of bytes; the slave modport is the transmitter.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  modport master (
    output data_in,
    output data_wr,
    input  fifo_full,
    input  fifo_empty,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  data_wr,
    output fifo_full,
    output fifo_empty,
    output overflow
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with a small transmit FIFO.
// Sends 8N1 frames (start 0, 8 data bits LSB first, stop 1), each bit held for
// CLKS_PER_BIT cycles of sys_clk. Bytes are latched from the FIFO only when a frame
// starts, so writes never disturb the frame on the line.
// Ports:
//   sys_clk : system clock, rising edge
//   reset   : synchronous active-high reset; aborts any frame and empties the FIFO
//   bus     : write-side interface (data_in, data_wr, fifo_full, fifo_empty, overflow)
//   TX      : serial line, idle high, driven straight from a flop
//   tx_busy : high whenever the transmitter is not idle
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic     sys_clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     TX,
  output logic     tx_busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
  localparam logic [15:0]   LastCnt = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [1:0]    state_q, state_d;
  logic [15:0]   bitcnt_q, bitcnt_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          full, empty, push, pop, terminal;

  // Flags come from the registered count only, so data_wr never reaches them.
  assign full     = (count_q == FullCnt);
  assign empty    = (count_q == '0);
  assign terminal = (bitcnt_q == LastCnt);

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push = bus.data_wr && !full;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        bitcnt_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rptr_q];
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (terminal) begin
          bitcnt_d = '0;
          bitidx_d = '0;
          state_d  = DATA;
          tx_d     = shift_q[0];
        end else begin
          bitcnt_d = bitcnt_q + 16'd1;
        end
      end
      DATA: begin
        if (terminal) begin
          bitcnt_d = '0;
          shift_d  = {1'b0, shift_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // Next bit is the one that shifts into position 0.
            tx_d = shift_q[1];
          end
        end else begin
          bitcnt_d = bitcnt_q + 16'd1;
        end
      end
      STOP: begin
        if (terminal) begin
          bitcnt_d = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bitcnt_d = bitcnt_q + 16'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = '0;
        tx_d     = 1'b1;
      end
    endcase
  end

  always_comb begin
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = bus.data_wr && full;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      bitidx_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      bitidx_q   <= bitidx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge sys_clk) begin
    if (!reset && push) begin
      mem_q[wptr_q] <= bus.data_in;
    end
  end

  assign TX             = tx_q;
  assign tx_busy        = (state_q != IDLE);
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
  localparam int unsigned Cpb = 16;

  logic sys_clk = 1'b0;
  logic reset;
  logic TX;
  logic tx_busy;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus),
    .TX     (TX),
    .tx_busy(tx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Line receiver: samples each bit mid-way, records byte, framing error and start cycle.
  logic [7:0]  rx_b[$];
  bit          rx_bad[$];
  int unsigned rx_t[$];

  initial begin
    logic [7:0]  b;
    bit          bad;
    int unsigned t0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (TX === 1'b0) begin
        t0  = cyc;
        bad = 1'b0;
        repeat (8) @(posedge sys_clk);
        #2;
        if (TX !== 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge sys_clk);
          #2;
          b[i] = TX;
        end
        repeat (16) @(posedge sys_clk);
        #2;
        if (TX !== 1'b1) bad = 1'b1;
        rx_b.push_back(b);
        rx_bad.push_back(bad);
        rx_t.push_back(t0);
        repeat (7) @(posedge sys_clk);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rx_clear();
    rx_b.delete();
    rx_bad.delete();
    rx_t.delete();
  endtask

  // Returns the number of post-edge samples with tx_busy high until it drops.
  task automatic wait_idle(output int cnt);
    int g;
    g   = 0;
    cnt = 0;
    while (tx_busy === 1'b1 && g < 3000) begin
      tick();
      g++;
      if (tx_busy === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_wr = 1'b0;
    bus.data_in = 8'h00;
    tick();
    tick();
    n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", TX); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.fifo_empty); end
    n_vec++; if (bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    reset = 1'b0;
    tick();
    n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL idle_tx: got %b want 1", TX); end
  endtask

  task automatic test_single();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    rx_clear();
    bus.data_in = 8'hA5;
    bus.data_wr = 1'b1;
    tick();
    bus.data_wr = 1'b0;
    n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL single_pre_tx: got %b want 1", TX); end
    n_vec++; if (bus.fifo_empty !== 1'b0) begin n_err++; $display("FAIL single_queued: got %b want 0", bus.fifo_empty); end
    tick();
    for (int n = 0; n < 10; n++) begin
      for (int j = 0; j < int'(Cpb); j++) begin
        n_vec++;
        if (TX !== frame[n]) begin
          n_err++; $display("FAIL single_bit%0d_cyc%0d: got %b want %b", n, j, TX, frame[n]);
        end
        n_vec++;
        if (tx_busy !== 1'b1) begin
          n_err++; $display("FAIL single_busy%0d_%0d: got %b want 1", n, j, tx_busy);
        end
        n_vec++;
        if (bus.fifo_empty !== 1'b1) begin
          n_err++; $display("FAIL single_empty%0d_%0d: got %b want 1", n, j, bus.fifo_empty);
        end
        tick();
      end
    end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL single_done_busy: got %b want 0", tx_busy); end
    n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL single_done_tx: got %b want 1", TX); end
    n_vec++;
    if (rx_b.size() != 1 || rx_b[0] !== 8'hA5 || rx_bad[0]) begin
      n_err++; $display("FAIL single_rx: got %0d frames want 1 frame of a5", rx_b.size());
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int extra;
    rx_clear();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 8'(i + 1);
      bus.data_wr = 1'b1;
      tick();
      if (tx_busy === 1'b1) cnt++;
    end
    bus.data_wr = 1'b0;
    n_vec++; if (bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", bus.fifo_full); end
    n_vec++; if (bus.fifo_empty !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", bus.fifo_empty); end
    wait_idle(extra);
    cnt += extra;
    n_vec++; if (cnt != 640) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want 640", cnt); end
    n_vec++; if (rx_b.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", rx_b.size()); end
    for (int i = 0; i < 4 && i < rx_b.size(); i++) begin
      n_vec++;
      if (rx_b[i] !== 8'(i + 1) || rx_bad[i]) begin
        n_err++; $display("FAIL b2b_byte%0d: got %h bad=%0d want %h", i, rx_b[i], rx_bad[i], i + 1);
      end
      if (i > 0) begin
        n_vec++;
        if (rx_t[i] - rx_t[i-1] != 160) begin
          n_err++; $display("FAIL b2b_gap%0d: got %0d want 160", i, rx_t[i] - rx_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int cnt;
    int extra;
    rx_clear();
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      bus.data_in = 8'(8'h10 + j);
      bus.data_wr = 1'b1;
      tick();
      if (tx_busy === 1'b1) cnt++;
      n_vec++;
      if (bus.overflow !== (j == 5)) begin
        n_err++; $display("FAIL ovf_pulse%0d: got %b want %b", j, bus.overflow, j == 5);
      end
      if (j >= 4) begin
        n_vec++;
        if (bus.fifo_full !== 1'b1) begin
          n_err++; $display("FAIL ovf_full%0d: got %b want 1", j, bus.fifo_full);
        end
      end
    end
    bus.data_wr = 1'b0;
    tick();
    if (tx_busy === 1'b1) cnt++;
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    wait_idle(extra);
    cnt += extra;
    n_vec++; if (cnt != 800) begin n_err++; $display("FAIL ovf_busy_cycles: got %0d want 800", cnt); end
    n_vec++; if (rx_b.size() != 5) begin n_err++; $display("FAIL ovf_count: got %0d want 5", rx_b.size()); end
    for (int i = 0; i < 5 && i < rx_b.size(); i++) begin
      n_vec++;
      if (rx_b[i] !== 8'(8'h10 + i) || rx_bad[i]) begin
        n_err++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_b[i], 8'h10 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [3];
    int lows;
    bytes[0] = 8'h3C;
    bytes[1] = 8'h11;
    bytes[2] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = bytes[i];
      bus.data_wr = 1'b1;
      tick();
    end
    bus.data_wr = 1'b0;
    repeat (48) tick();
    n_vec++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_pre: got %b want 1", tx_busy); end
    // Write during reset must be ignored.
    reset = 1'b1;
    bus.data_in = 8'h99;
    bus.data_wr = 1'b1;
    tick();
    reset = 1'b0;
    bus.data_wr = 1'b0;
    n_vec++; if (TX !== 1'b1) begin n_err++; $display("FAIL rst_mid_tx: got %b want 1", TX); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", tx_busy); end
    n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty: got %b want 1", bus.fifo_empty); end
    n_vec++; if (bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL rst_mid_full: got %b want 0", bus.fifo_full); end
    tick();
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_stays_idle: got %b want 0", tx_busy); end
    repeat (200) tick();
    rx_clear();
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (TX !== 1'b1) lows++;
    end
    n_vec++; if (lows != 0) begin n_err++; $display("FAIL rst_mid_line: got %0d low cycles want 0", lows); end
    n_vec++; if (rx_b.size() != 0) begin n_err++; $display("FAIL rst_mid_frames: got %0d want 0", rx_b.size()); end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    int extra;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    rx_clear();
    for (int i = 0; i < 3; i++) begin
      bus.data_in = bytes[i];
      bus.data_wr = 1'b1;
      tick();
    end
    bus.data_wr = 1'b0;
    wait_idle(extra);
    n_vec++; if (extra != 478) begin n_err++; $display("FAIL loop_busy_cycles: got %0d want 478", extra); end
    n_vec++; if (rx_b.size() != 3) begin n_err++; $display("FAIL loop_count: got %0d want 3", rx_b.size()); end
    for (int i = 0; i < 3 && i < rx_b.size(); i++) begin
      n_vec++;
      if (rx_b[i] !== bytes[i]) begin
        n_err++; $display("FAIL loop_byte%0d: got %h want %h", i, rx_b[i], bytes[i]);
      end
      n_vec++;
      if (rx_bad[i]) begin
        n_err++; $display("FAIL loop_corrupt%0d: got 1 want 0", i);
      end
    end
  endtask

  initial begin
    bus.data_in = 8'h00;
    bus.data_wr = 1'b0;
    reset       = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL provide parameter CLKS_PER_BIT, default 16, meaning sys_clk cycles per serial bit (16x oversampled baud at the receiver), legal range 2..65535.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 4, meaning transmit FIFO word capacity, power of two, 2..64.
REQ-003 The block SHALL have port sys_clk  input  1  single system clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port data_in  input  8  byte to transmit.
REQ-006 The block SHALL have port data_wr  input  1  write strobe; data_in pushed into FIFO on an edge where data_wr=1 and fifo_full=0.
REQ-007 The block SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH words.
REQ-008 The block SHALL have port fifo_empty  output  1  FIFO holds zero words.
REQ-009 The block SHALL have port overflow  output  1  one-cycle pulse when a write is dropped because the FIFO is full.
REQ-010 The block SHALL have port TX  output  1  serial line, idle high, registered output.
REQ-011 The block SHALL have port tx_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 Frame format SHALL be: start bit 0, 8 data bits LSB first, stop bit 1; no parity; frame length exactly 10*CLKS_PER_BIT cycles.
REQ-013 Every bit, including start and stop, SHALL hold TX for exactly CLKS_PER_BIT cycles, timed by a bit counter 0..CLKS_PER_BIT-1.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: TX=1; if fifo_empty=0, pop head word into shift register, clear bit counter, go START.
REQ-016 START: TX=0; at bit-counter terminal count go DATA with bit index 0.
REQ-017 DATA: TX=shift[0]; at terminal count shift right one place, increment bit index; after index 7 terminal count go STOP.
REQ-018 STOP: TX=1; at terminal count, if FIFO non-empty pop next word and go START directly (no idle gap), else go IDLE.
REQ-019 Latency: a write accepted at edge k into an empty FIFO with FSM in IDLE SHALL cause TX to fall at edge k+1.
REQ-020 FIFO SHALL be first-in first-out with wrapping read/write pointers and a count of width log2(FIFO_DEPTH)+1.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-022 Write while fifo_full=1 SHALL be dropped and overflow pulsed, even if a pop occurs on the same edge.
REQ-023 data_wr SHALL have no effect on the frame in progress; bytes are latched at pop time only.
REQ-024 fifo_full, fifo_empty and tx_busy SHALL reflect registered state after each edge (no combinational path from data_wr).

Reset
REQ-025 With reset=1 at an edge: state=IDLE, TX=1, tx_busy=0, overflow=0, FIFO pointers and count=0, fifo_empty=1, fifo_full=0, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame, return TX to 1 at that edge, and discard all FIFO contents.
REQ-027 data_wr SHALL be ignored on any edge where reset=1.

Verification (CLKS_PER_BIT=16, sys_clk period 10 ns)
REQ-028 Single byte 0xA5 written while idle -> TX falls next edge; line reads 0,1,0,1,0,0,1,0,1,1 each 160 ns; tx_busy high 1600 ns then low; fifo_empty=1 throughout frame.
REQ-029 Four bytes 0x01,0x02,0x03,0x04 on consecutive cycles -> fifo_full=0 after all four (first popped), frames back-to-back with no idle gap, total 6400 ns, bytes in order.
REQ-030 Six consecutive writes with FIFO_DEPTH=4 while idle -> first five accepted (one popped immediately), sixth dropped with one overflow pulse; five frames emitted.
REQ-031 reset pulsed mid-DATA of byte 0x3C with two bytes queued -> TX=1 after the edge, tx_busy=0, fifo_empty=1, no further frames.
REQ-032 Loopback: TX wired to the receiver block, bytes 0x00, 0xFF, 0x55 -> receiver data_out matches each byte, data_corrupted stays 0.
